// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the alu_arbiter block: ALU function codes,
// arbiter FSM states and the maximum requester count.
package alu_arb_pkg;

    localparam int MAX_REQ = 4;

    typedef enum logic [2:0] {
        ADD  = 3'b000,
        SLL  = 3'b001,
        SLT  = 3'b010,
        SLTU = 3'b011,
        XOR  = 3'b100,
        SRL  = 3'b101,
        OR   = 3'b110,
        AND  = 3'b111
    } alu_op_e;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational request picker: scans valid from the start index upward
// (wrapping at NUM_REQ) and returns a one-hot grant for the first valid entry.
module alu_arb_pick
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [MAX_REQ-1:0] valid,
    input  logic [1:0]         start,
    output logic [MAX_REQ-1:0] grant
);

    logic       found;
    logic [2:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, start} + 3'(k);
            if (idx >= 3'(NUM_REQ)) begin
                idx = idx - 3'(NUM_REQ);
            end
            if (!found && valid[idx[1:0]]) begin
                grant[idx[1:0]] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 32-bit ALU among NUM_REQ requesters with a 2-cycle registered path.
// Build option ALU_ARB_RR_EN selects round-robin arbitration (default: fixed priority).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ-1:0]     req_lock_i,
    input  logic [NUM_REQ*32-1:0]  req_in1_i,
    input  logic [NUM_REQ*32-1:0]  req_in2_i,
    input  logic [NUM_REQ*3-1:0]   req_op_i,
    input  logic [NUM_REQ-1:0]     req_qual_i,
    output logic [NUM_REQ-1:0]     resp_valid_o,
    output logic [31:0]            resp_data_o,
    output arb_state_e             dbg_state_o,
    output logic [1:0]             dbg_ptr_o
);

    // Handshake: requester i transfers an op on a rising edge where
    // req_valid_i[i] & req_ready_o[i]; ready is never high without valid.
    logic [MAX_REQ-1:0]    valid_pad, lock_pad, qual_pad;
    logic [MAX_REQ*32-1:0] in1_pad, in2_pad;
    logic [MAX_REQ*3-1:0]  op_pad;
    logic [31:0]           in1_arr [MAX_REQ];
    logic [31:0]           in2_arr [MAX_REQ];
    logic [2:0]            op_arr  [MAX_REQ];

    assign valid_pad = MAX_REQ'(req_valid_i);
    assign lock_pad  = MAX_REQ'(req_lock_i);
    assign qual_pad  = MAX_REQ'(req_qual_i);
    assign in1_pad   = (MAX_REQ*32)'(req_in1_i);
    assign in2_pad   = (MAX_REQ*32)'(req_in2_i);
    assign op_pad    = (MAX_REQ*3)'(req_op_i);

    always_comb begin
        for (int k = 0; k < MAX_REQ; k++) begin
            in1_arr[k] = in1_pad[32*k +: 32];
            in2_arr[k] = in2_pad[32*k +: 32];
            op_arr[k]  = op_pad[3*k +: 3];
        end
    end

    arb_state_e         state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         pick_start;
    logic [MAX_REQ-1:0] pick_grant;
    logic [MAX_REQ-1:0] ready_pad;
    logic               hs;
    logic [1:0]         hs_idx;

    alu_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid (valid_pad),
        .start (pick_start),
        .grant (pick_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            owner_q <= 2'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // In LOCK the owner's handshake in the releasing cycle is still granted.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ready_pad = '0;
        case (state_q)
            ARB:     ready_pad = pick_grant;
            LOCK:    ready_pad = valid_pad & (MAX_REQ'(1) << owner_q);
            default: ready_pad = '0;
        endcase
        hs     = |ready_pad;
        hs_idx = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (ready_pad[k]) begin
                hs_idx = 2'(k);
            end
        end
        if (state_q == ARB && hs && lock_pad[hs_idx]) begin
            state_d = LOCK;
            owner_d = hs_idx;
        end else if (state_q == LOCK && !lock_pad[owner_q]) begin
            state_d = ARB;
        end
    end

    assign req_ready_o = ready_pad[NUM_REQ-1:0];
    assign dbg_state_o = state_q;

`ifdef ALU_ARB_RR_EN
    logic [1:0] ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else if (state_q == ARB && hs) begin
            ptr_q <= (hs_idx == 2'(NUM_REQ - 1)) ? 2'd0 : hs_idx + 2'd1;
        end
    end

    assign pick_start = ptr_q;
`else
    assign pick_start = 2'd0;
`endif

    assign dbg_ptr_o = pick_start;

    logic        iss_valid;
    logic [1:0]  iss_tag;
    logic [31:0] iss_in1, iss_in2;
    alu_op_e     iss_op;
    logic        iss_qual;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid <= 1'b0;
            iss_tag   <= 2'd0;
            iss_in1   <= '0;
            iss_in2   <= '0;
            iss_op    <= ADD;
            iss_qual  <= 1'b0;
        end else begin
            iss_valid <= hs;
            if (hs) begin
                iss_tag  <= hs_idx;
                iss_in1  <= in1_arr[hs_idx];
                iss_in2  <= in2_arr[hs_idx];
                iss_op   <= alu_op_e'(op_arr[hs_idx]);
                iss_qual <= qual_pad[hs_idx];
            end
        end
    end

    logic [4:0]         shamt;
    logic signed [31:0] sra_res;
    logic [31:0]        alu_res;
    logic [NUM_REQ-1:0] resp_d;

    assign shamt   = iss_in2[4:0];
    assign sra_res = $signed(iss_in1) >>> shamt;

    always_comb begin
        alu_res = '0;
        case (iss_op)
            ADD:     alu_res = iss_qual ? (iss_in1 - iss_in2) : (iss_in1 + iss_in2);
            SLL:     alu_res = iss_in1 << shamt;
            SLT:     alu_res = {31'd0, ($signed(iss_in1) < $signed(iss_in2))};
            SLTU:    alu_res = {31'd0, (iss_in1 < iss_in2)};
            XOR:     alu_res = iss_in1 ^ iss_in2;
            SRL:     alu_res = iss_qual ? sra_res : (iss_in1 >> shamt);
            OR:      alu_res = iss_in1 | iss_in2;
            AND:     alu_res = iss_in1 & iss_in2;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        resp_d = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            resp_d[k] = iss_valid && (iss_tag == 2'(k));
        end
    end

    // Result data holds its last value when no op completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_o <= '0;
            resp_data_o  <= '0;
        end else begin
            resp_valid_o <= resp_d;
            if (iss_valid) begin
                resp_data_o <= alu_res;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with two requesters; grant
// expectations follow whichever arbitration build (ALU_ARB_RR_EN) is compiled.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int N = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_lock, req_qual, resp_valid;
    logic [N*32-1:0] req_in1, req_in2;
    logic [N*3-1:0]  req_op;
    logic [31:0]     resp_data;
    arb_state_e      dbg_state;
    logic [1:0]      dbg_ptr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_lock_i   (req_lock),
        .req_in1_i    (req_in1),
        .req_in2_i    (req_in2),
        .req_op_i     (req_op),
        .req_qual_i   (req_qual),
        .resp_valid_o (resp_valid),
        .resp_data_o  (resp_data),
        .dbg_state_o  (dbg_state),
        .dbg_ptr_o    (dbg_ptr)
    );

    task automatic set_req(input int i, input logic v, input logic lk, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] o, input logic q);
        req_valid[i]        = v;
        req_lock[i]         = lk;
        req_in1[32*i +: 32] = a;
        req_in2[32*i +: 32] = b;
        req_op[3*i +: 3]    = o;
        req_qual[i]         = q;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_lock  = '0;
        req_qual  = '0;
        req_in1   = '0;
        req_in2   = '0;
        req_op    = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 2'b00) begin
            failures++; $display("FAIL reset_resp_valid got=%b exp=%b", resp_valid, 2'b00);
        end
        checks++;
        if (resp_data !== 32'h0) begin
            failures++; $display("FAIL reset_resp_data got=%h exp=%h", resp_data, 32'h0);
        end
        checks++;
        if (dbg_state !== ARB) begin
            failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ARB);
        end
        checks++;
        if (dbg_ptr !== 2'd0) begin
            failures++; $display("FAIL reset_ptr got=%0d exp=0", dbg_ptr);
        end
        checks++;
        if (req_ready !== 2'b00) begin
            failures++; $display("FAIL reset_ready_idle got=%b exp=%b", req_ready, 2'b00);
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++; $display("FAIL reset_ready_both got=%b exp=%b", req_ready, 2'b01);
        end
        clear_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        apply_reset();
        set_req(0, 1'b1, 1'b0, 32'd5, 32'd7, 3'b000, 1'b1);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++; $display("FAIL single_ready got=%b exp=%b", req_ready, 2'b01);
        end
        @(posedge clk);
        #1 clear_inputs();
        checks++;
        if (resp_valid !== 2'b00) begin
            failures++; $display("FAIL single_early got=%b exp=%b", resp_valid, 2'b00);
        end
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 2'b01) begin
            failures++; $display("FAIL single_resp_valid got=%b exp=%b", resp_valid, 2'b01);
        end
        checks++;
        if (resp_data !== 32'hFFFF_FFFE) begin
            failures++; $display("FAIL single_resp_data got=%h exp=%h", resp_data, 32'hFFFF_FFFE);
        end
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 2'b00) begin
            failures++; $display("FAIL single_one_cycle got=%b exp=%b", resp_valid, 2'b00);
        end
        checks++;
        if (resp_data !== 32'hFFFF_FFFE) begin
            failures++; $display("FAIL single_data_hold got=%h exp=%h", resp_data, 32'hFFFF_FFFE);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_rdy, prev_tag, cur_tag;
        logic [31:0] prev_data, cur_data;
        apply_reset();
        prev_tag  = 2'b00;
        prev_data = '0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                set_req(0, 1'b1, 1'b0, 32'd1, 32'd1, 3'b000, 1'b0);
                set_req(1, 1'b1, 1'b0, 32'd2, 32'd2, 3'b000, 1'b0);
            end else begin
                clear_inputs();
            end
            #1;
            if (k >= 4) begin
                exp_rdy = 2'b00;
            end else begin
`ifdef ALU_ARB_RR_EN
                exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
                exp_rdy = 2'b01;
`endif
            end
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++; $display("FAIL contend_ready[%0d] got=%b exp=%b", k, req_ready, exp_rdy);
            end
            cur_tag  = exp_rdy;
            cur_data = (exp_rdy == 2'b01) ? 32'd2 : (exp_rdy == 2'b10) ? 32'd4 : 32'd0;
            @(posedge clk);
            #1;
            checks++;
            if (resp_valid !== prev_tag) begin
                failures++; $display("FAIL contend_resp_tag[%0d] got=%b exp=%b", k, resp_valid, prev_tag);
            end
            if (prev_tag != 2'b00) begin
                checks++;
                if (resp_data !== prev_data) begin
                    failures++; $display("FAIL contend_resp_data[%0d] got=%h exp=%h", k, resp_data, prev_data);
                end
            end
            prev_tag  = cur_tag;
            prev_data = cur_data;
        end
    endtask

    task automatic test_lock();
        logic [1:0] tv [6];
        logic [1:0] tl [6];
        logic [1:0] tr [6];
        arb_state_e ts [6];
        tv = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
        tl = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        tr = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b01};
        ts = '{ARB,   LOCK,  LOCK,  LOCK,  LOCK,  ARB};
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            set_req(0, tv[k][0], tl[k][0], 32'd3, 32'd3, 3'b000, 1'b0);
            set_req(1, tv[k][1], tl[k][1], 32'd4, 32'd4, 3'b000, 1'b0);
            #1;
            checks++;
            if (req_ready !== tr[k]) begin
                failures++; $display("FAIL lock_ready[%0d] got=%b exp=%b", k, req_ready, tr[k]);
            end
            checks++;
            if (dbg_state !== ts[k]) begin
                failures++; $display("FAIL lock_state[%0d] got=%0d exp=%0d", k, dbg_state, ts[k]);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_alu_ops();
        logic [2:0]  to [11];
        logic        tq [11];
        logic [31:0] ta [11];
        logic [31:0] tb [11];
        logic [31:0] te [11];
        to = '{3'b101, 3'b101, 3'b010, 3'b011, 3'b010, 3'b001, 3'b000, 3'b100, 3'b110, 3'b111, 3'b101};
        tq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ta = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,
               32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h7FFF_FFFF};
        tb = '{32'h4, 32'h4, 32'h1, 32'h1, 32'h1, 32'h3F,
               32'h1, 32'hFF00_FF00, 32'h0F00_0000, 32'hFF00_FF00, 32'h21};
        te = '{32'hF800_0000, 32'h0800_0000, 32'h1, 32'h0, 32'h1, 32'h8000_0000,
               32'h0, 32'h0FF0_0FF0, 32'hFFF0_F0F0, 32'hF000_F000, 32'h3FFF_FFFF};
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            if (k < 11) begin
                set_req(0, 1'b1, 1'b0, ta[k], tb[k], to[k], tq[k]);
            end else begin
                clear_inputs();
            end
            @(posedge clk);
            #1;
            if (k == 0) begin
                checks++;
                if (resp_valid !== 2'b00) begin
                    failures++; $display("FAIL alu_first got=%b exp=%b", resp_valid, 2'b00);
                end
            end else begin
                checks++;
                if (resp_valid !== 2'b01) begin
                    failures++; $display("FAIL alu_valid[%0d] got=%b exp=%b", k - 1, resp_valid, 2'b01);
                end
                checks++;
                if (resp_data !== te[k-1]) begin
                    failures++; $display("FAIL alu_data[%0d] got=%h exp=%h", k - 1, resp_data, te[k-1]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        set_req(0, 1'b1, 1'b0, 32'd3, 32'd4, 3'b000, 1'b0);
        @(posedge clk);
        #1 clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 2'b00) begin
            failures++; $display("FAIL midrst_resp_valid got=%b exp=%b", resp_valid, 2'b00);
        end
        checks++;
        if (resp_data !== 32'h0) begin
            failures++; $display("FAIL midrst_resp_data got=%h exp=%h", resp_data, 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 2'b00) begin
            failures++; $display("FAIL midrst_after got=%b exp=%b", resp_valid, 2'b00);
        end
        checks++;
        if (dbg_state !== ARB) begin
            failures++; $display("FAIL midrst_state got=%0d exp=%0d", dbg_state, ARB);
        end
        checks++;
        if (dbg_ptr !== 2'd0) begin
            failures++; $display("FAIL midrst_ptr got=%0d exp=0", dbg_ptr);
        end
        set_req(0, 1'b1, 1'b0, 32'd9, 32'd1, 3'b000, 1'b0);
        @(posedge clk);
        #1 clear_inputs();
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 2'b01 || resp_data !== 32'hA) begin
            failures++; $display("FAIL midrst_recover got=%b/%h exp=%b/%h", resp_valid, resp_data, 2'b01, 32'hA);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_back_to_back();
        test_lock();
        test_alu_ops();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
